// File: rtl/axi_lite_master_bridge.sv
// Strobe/ack register-bus to AXI-lite initiator, one transaction in flight at a time.
// A per-wait-state watchdog turns a stalled responder into an error completion.
module axi_lite_master_bridge #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 4,
   parameter int TIMEOUT       = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     up_wreq,
   input  logic [ADDRESS_WIDTH-1:0] up_waddr,
   input  logic [BUS_WIDTH*8-1:0]   up_wdata,
   input  logic [BUS_WIDTH-1:0]     up_wstrb,
   output logic                     up_wack,
   output logic                     up_werr,
   input  logic                     up_rreq,
   input  logic [ADDRESS_WIDTH-1:0] up_raddr,
   output logic [BUS_WIDTH*8-1:0]   up_rdata,
   output logic                     up_rack,
   output logic                     up_rerr,
   output logic                     up_busy,
   output logic                     m_axi_awvalid,
   output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]               m_axi_awprot,
   input  logic                     m_axi_awready,
   output logic                     m_axi_wvalid,
   output logic [BUS_WIDTH*8-1:0]   m_axi_wdata,
   output logic [BUS_WIDTH-1:0]     m_axi_wstrb,
   input  logic                     m_axi_wready,
   input  logic                     m_axi_bvalid,
   input  logic [1:0]               m_axi_bresp,
   output logic                     m_axi_bready,
   output logic                     m_axi_arvalid,
   output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]               m_axi_arprot,
   input  logic                     m_axi_arready,
   input  logic                     m_axi_rvalid,
   input  logic [BUS_WIDTH*8-1:0]   m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   output logic                     m_axi_rready,
   output logic [2:0]               o_dbg_state
);
   localparam int DW = BUS_WIDTH * 8;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DW-1:0]            r_wdata;
   logic [BUS_WIDTH-1:0]     r_wstrb;
   logic [DW-1:0]            r_rbuf;
   logic [DW-1:0]            r_rdata;
   logic                     r_is_wr, r_err, r_aw_done, r_w_done;
   logic                     r_wack, r_werr, r_rack, r_rerr;
   logic [TW-1:0]            r_timer;
   logic [TW-1:0]            w_timer_inc;
   logic                     w_busy, w_tmo, w_hs, w_wait, w_abort;
   logic                     w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

   // Valid/ready handshake: a transfer happens on any rising edge where both are high;
   // valids and payload are held until that edge, except on a watchdog abort.
   assign m_axi_awvalid = (r_state == WR_REQ) && !r_aw_done;
   assign m_axi_wvalid  = (r_state == WR_REQ) && !r_w_done;
   assign m_axi_bready  = (r_state == WR_RESP);
   assign m_axi_arvalid = (r_state == RD_REQ);
   assign m_axi_rready  = (r_state == RD_RESP);
   assign m_axi_awaddr  = r_addr;
   assign m_axi_araddr  = r_addr;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;

   assign w_aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_w_hs  = m_axi_wvalid & m_axi_wready;
   assign w_b_hs  = m_axi_bvalid & m_axi_bready;
   assign w_ar_hs = m_axi_arvalid & m_axi_arready;
   assign w_r_hs  = m_axi_rvalid & m_axi_rready;

   // The ack cycle still counts as busy, so a strobe coincident with an ack is dropped.
   assign w_busy      = (r_state != IDLE) || r_wack || r_rack;
   assign w_timer_inc = r_timer + TW'(1);
   assign w_tmo       = (TIMEOUT != 0) && (w_timer_inc == TO_VAL);

   assign up_wack     = r_wack;
   assign up_werr     = r_werr;
   assign up_rack     = r_rack;
   assign up_rerr     = r_rerr;
   assign up_rdata    = r_rdata;
   assign up_busy     = w_busy;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_hs    = 1'b0;
      w_wait  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_busy) begin
               if (up_wreq)      w_next = WR_REQ;
               else if (up_rreq) w_next = RD_REQ;
            end
         end
         WR_REQ: begin
            w_wait = 1'b1;
            w_hs   = w_aw_hs | w_w_hs;
            if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = WR_RESP;
            else if (w_tmo && !w_hs) begin w_next = DONE; w_abort = 1'b1; end
         end
         WR_RESP: begin
            w_wait = 1'b1;
            w_hs   = w_b_hs;
            if (w_b_hs) w_next = DONE;
            else if (w_tmo) begin w_next = DONE; w_abort = 1'b1; end
         end
         RD_REQ: begin
            w_wait = 1'b1;
            w_hs   = w_ar_hs;
            if (w_ar_hs) w_next = RD_RESP;
            else if (w_tmo) begin w_next = DONE; w_abort = 1'b1; end
         end
         RD_RESP: begin
            w_wait = 1'b1;
            w_hs   = w_r_hs;
            if (w_r_hs) w_next = DONE;
            else if (w_tmo) begin w_next = DONE; w_abort = 1'b1; end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || (w_next != r_state) || w_hs) r_timer <= '0;
      else if (w_wait && (TIMEOUT != 0))      r_timer <= w_timer_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rbuf    <= '0;
         r_rdata   <= '0;
         r_is_wr   <= 1'b0;
         r_err     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_wack    <= 1'b0;
         r_werr    <= 1'b0;
         r_rack    <= 1'b0;
         r_rerr    <= 1'b0;
      end else begin
         if (r_state == IDLE && w_next == WR_REQ) begin
            r_addr    <= up_waddr;
            r_wdata   <= up_wdata;
            r_wstrb   <= up_wstrb;
            r_is_wr   <= 1'b1;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (r_state == IDLE && w_next == RD_REQ) begin
            r_addr  <= up_raddr;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_rbuf  <= '0;
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
         if (w_b_hs)  r_err     <= |m_axi_bresp;
         if (w_r_hs) begin
            r_rbuf <= m_axi_rdata;
            r_err  <= |m_axi_rresp;
         end
         if (w_abort) r_err <= 1'b1;
         r_wack <= (r_state == DONE) && r_is_wr;
         r_werr <= (r_state == DONE) && r_is_wr && r_err;
         r_rack <= (r_state == DONE) && !r_is_wr;
         r_rerr <= (r_state == DONE) && !r_is_wr && r_err;
         if (r_state == DONE && !r_is_wr) r_rdata <= r_rbuf;
      end
   end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: configurable AXI-lite responder plus
// an ack scoreboard fed by the request steps.
module tb_axi_lite_master_bridge;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int EW = 2 + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_wreq, up_rreq;
   logic [AW-1:0] up_waddr, up_raddr;
   logic [DW-1:0] up_wdata, up_rdata;
   logic [3:0]    up_wstrb;
   logic          up_wack, up_werr, up_rack, up_rerr, up_busy;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot, dbg_state;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;

   int n_cmp = 0;
   int n_err = 0;
   int n_ack = 0;
   logic [EW-1:0] exp_q[$];

   int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0;
   bit          cfg_aw_never = 0, cfg_w_never = 0, cfg_ar_never = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [DW-1:0] cfg_rdata = '0;
   bit          ar_seen = 0;
   int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

   int          start_ack, hi_cnt, ack_cyc;
   logic [DW-1:0] rnd;

   axi_lite_master_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
      .up_wack(up_wack), .up_werr(up_werr),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
      .up_rack(up_rack), .up_rerr(up_rerr), .up_busy(up_busy),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awready(m_axi_awready),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rready(m_axi_rready),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ctrl_vec();
      return {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
              up_wack, up_werr, up_rack, up_rerr, up_busy};
   endfunction

   // Responder: readies after a programmable number of valid cycles; responses answer the ready.
   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      forever begin
         @(negedge clk);
         m_axi_awready = m_axi_awvalid && !cfg_aw_never && (aw_cnt >= cfg_aw_wait);
         m_axi_wready  = m_axi_wvalid && !cfg_w_never && (w_cnt >= cfg_w_wait);
         m_axi_arready = m_axi_arvalid && !cfg_ar_never && (ar_cnt >= cfg_ar_wait);
         aw_cnt = m_axi_awvalid ? aw_cnt + 1 : 0;
         w_cnt  = m_axi_wvalid ? w_cnt + 1 : 0;
         ar_cnt = m_axi_arvalid ? ar_cnt + 1 : 0;
         if (m_axi_arvalid) ar_seen = 1;
         m_axi_bvalid = m_axi_bready;
         m_axi_bresp  = cfg_bresp;
         m_axi_rvalid = m_axi_rready;
         m_axi_rresp  = cfg_rresp;
         m_axi_rdata  = cfg_rdata;
      end
   end

   // Completion monitor: every ack pops one expected {is_write, err, rdata} entry.
   initial begin
      logic [EW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && (up_wack || up_rack)) begin
            n_ack++;
            check("ack_exclusive", {up_wack, up_rack}, up_wack ? 2'b10 : 2'b01);
            check("ack_expected_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               check("ack_result", {up_wack, up_wack ? up_werr : up_rerr, up_wack ? 32'h0 : up_rdata}, exp);
            end
         end
      end
   end

   task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      @(negedge clk);
      up_wreq = 1; up_waddr = a; up_wdata = d; up_wstrb = s;
      @(negedge clk);
      up_wreq = 0;
   endtask

   task automatic send_read(input logic [AW-1:0] a);
      @(negedge clk);
      up_rreq = 1; up_raddr = a;
      @(negedge clk);
      up_rreq = 0;
   endtask

   task automatic wait_ack(input string tag, input int budget);
      int start;
      bit got;
      start = n_ack;
      got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (n_ack != start) begin got = 1; break; end
      end
      check(tag, got, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1; up_wreq = 0; up_rreq = 0; up_waddr = 0; up_raddr = 0; up_wdata = 0; up_wstrb = 0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", ctrl_vec(), 10'h0);
      check("reset_rdata", up_rdata, 32'h0);
      check("reset_state", dbg_state, 3'd0);
      rst = 0;

      // Zero-wait write with exact cycle timing.
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      send_write(16'h0010, 32'hDEADBEEF, 4'hF);
      check("t1_c1_valids", {m_axi_awvalid, m_axi_wvalid, up_busy}, 3'b111);
      check("t1_c1_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot}, {16'h0010, 32'hDEADBEEF, 4'hF, 3'b000});
      @(negedge clk);
      check("t1_c2_bready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
      @(negedge clk); #1;
      check("t1_c3_noack", {m_axi_bready, up_wack, up_busy}, 3'b001);
      @(negedge clk); #1;
      check("t1_c4_ack", {up_wack, up_werr, up_busy}, 3'b101);
      @(negedge clk); #1;
      check("t1_c5_idle", {up_wack, up_busy}, 2'b00);

      // wready well before awready: wvalid drops alone, aw payload held.
      cfg_aw_wait = 3;
      rnd = $urandom_range(1, 32'h7FFF_FFFF);
      start_ack = n_ack;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      send_write(16'h0010, rnd, 4'h3);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         check("t2_aw_held", {m_axi_awvalid, m_axi_wvalid, m_axi_awaddr}, {2'b10, 16'h0010});
      end
      wait_ack("t2_wait_ack", 20);
      repeat (5) @(negedge clk);
      check("t2_single_ack", n_ack - start_ack, 1);
      cfg_aw_wait = 0;

      // Read back with data hold after the ack.
      cfg_rdata = 32'hDEADBEEF;
      exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
      send_read(16'h0010);
      check("t3_ar", {m_axi_arvalid, m_axi_araddr, m_axi_arprot}, {1'b1, 16'h0010, 3'b000});
      wait_ack("t3_wait_ack", 20);
      cfg_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("t3_rdata_hold", up_rdata, 32'hDEADBEEF);

      // Simultaneous strobes, then reads while busy (incl. the ack cycle): only the write runs.
      ar_seen = 0;
      start_ack = n_ack;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      @(negedge clk);
      up_wreq = 1; up_rreq = 1; up_waddr = 16'h0020; up_raddr = 16'h0030; up_wdata = 32'h1; up_wstrb = 4'hF;
      @(negedge clk);
      up_wreq = 0; up_rreq = 0;
      check("t4_awaddr", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 16'h0020});
      @(negedge clk); up_rreq = 1;
      @(negedge clk); up_rreq = 0;
      @(negedge clk); up_rreq = 1; #1;
      check("t4_ack_cycle", {up_wack, up_busy}, 2'b11);
      @(negedge clk); up_rreq = 0;
      repeat (6) @(negedge clk);
      #1;
      check("t4_no_ar", {ar_seen, up_busy}, 2'b00);
      check("t4_single_ack", n_ack - start_ack, 1);

      // Write watchdog: responder never accepts; eight valid cycles, then error ack.
      cfg_aw_never = 1; cfg_w_never = 1;
      hi_cnt = 0; ack_cyc = 0;
      exp_q.push_back({1'b1, 1'b1, 32'h0});
      send_write(16'h0050, 32'h55AA55AA, 4'hF);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (m_axi_awvalid) hi_cnt++;
         if (up_wack) ack_cyc = c;
      end
      check("t5_aw_valid_cycles", hi_cnt, 8);
      check("t5_ack_cycle", ack_cyc, 10);
      cfg_aw_never = 0; cfg_w_never = 0;

      // Read watchdog: abort returns zero data.
      cfg_ar_never = 1;
      exp_q.push_back({1'b0, 1'b1, 32'h0});
      send_read(16'h0060);
      wait_ack("t6_wait_ack", 20);
      cfg_ar_never = 0;

      // Error responses.
      cfg_bresp = 2'b10;
      exp_q.push_back({1'b1, 1'b1, 32'h0});
      send_write(16'h0070, 32'h0BADF00D, 4'h1);
      wait_ack("t7_wait_wack", 20);
      cfg_bresp = 2'b00;
      rnd = $urandom() | 32'h1;
      cfg_rdata = rnd; cfg_rresp = 2'b11;
      exp_q.push_back({1'b0, 1'b1, rnd});
      send_read(16'h0074);
      wait_ack("t7_wait_rack", 20);
      cfg_rresp = 2'b00;

      // Reset in the middle of a read: everything clears, no ack.
      cfg_ar_wait = 5;
      start_ack = n_ack;
      send_read(16'h0040);
      check("t8_ar_active", m_axi_arvalid, 1'b1);
      @(negedge clk); rst = 1;
      @(negedge clk);
      check("t8_reset_ctrl", ctrl_vec(), 10'h0);
      check("t8_reset_rdata", {up_rdata, dbg_state}, 35'h0);
      rst = 0;
      repeat (10) @(negedge clk);
      #1;
      check("t8_no_ack", n_ack - start_ack, 0);
      check("t8_idle", {up_busy, m_axi_arvalid}, 2'b00);
      cfg_ar_wait = 0;

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
